adder_sched: RTL and testbench
==============================

ADDER_SCHED -- requirements
Module: adder_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the operand width of every requester.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the number of requesters (2..8); ID_WIDTH = clog2(NUM_REQ).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 req_i  input  NUM_REQ  SHALL carry one request bit per requester.
REQ-006 data1_i  input  NUM_REQ*DATA_WIDTH  SHALL carry first operands; requester k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 data2_i  input  NUM_REQ*DATA_WIDTH  SHALL carry second operands, same packing as data1_i.
REQ-008 gnt_o  output  NUM_REQ  SHALL be a one-hot (or zero) grant, combinational from req_i, priority pointer and stall.
REQ-009 result_o  output  DATA_WIDTH+1  SHALL carry the registered unsigned sum, carry in MSB.
REQ-010 result_id_o  output  ID_WIDTH  SHALL carry the index of the requester owning result_o.
REQ-011 result_valid_o  output  1  SHALL flag result_o/result_id_o as valid.
REQ-012 result_ready_i  input  1  SHALL be consumer back-pressure; a result transfers on a cycle with result_valid_o and result_ready_i both high.

Function
REQ-013 Operands SHALL be captured into stage 1 (op1, op2, id, s1_valid) at the rising edge ending any cycle in which gnt_o is non-zero.
REQ-014 A requester SHALL hold req_i and its operands stable until it sees its gnt_o bit high; the grant bit is high for exactly that capture cycle.
REQ-015 Stage 1 SHALL feed one instance of adder; the adder output SHALL be registered into stage 2 (result_o, result_id_o, result_valid_o).
REQ-016 Latency SHALL be 2 cycles: grant in cycle N gives result_valid_o high in cycle N+2 when not stalled.
REQ-017 Throughput SHALL be one grant per cycle while requests are pending and no stall exists.
REQ-018 Stall SHALL equal result_valid_o AND NOT result_ready_i; during stall stages 1 and 2 hold, and gnt_o is zero if s1_valid is high.
REQ-019 During stall with s1_valid low, one grant SHALL still be issued to fill stage 1 (bubble collapse).
REQ-020 Arbitration SHALL be round-robin: search from pointer upward with wrap, grant first set req_i bit.
REQ-021 After a grant to index k, the pointer SHALL become (k+1) mod NUM_REQ; no grant leaves the pointer unchanged.
REQ-022 req_i all zero SHALL give gnt_o zero and no stage-1 capture.
REQ-023 Stage 2 SHALL drop result_valid_o after a transfer unless stage 1 advances a new result the same edge.
REQ-024 Sum SHALL be full-width: 0xFFFF + 0x0001 at DATA_WIDTH 16 gives 0x10000, never wrapped.

Reset
REQ-025 rst high SHALL immediately clear s1_valid, result_valid_o, result_o, result_id_o and set the pointer to 0; gnt_o SHALL be zero while rst is high.
REQ-026 Reset asserted mid-operation SHALL discard in-flight operations; no result SHALL emerge for them after release.
REQ-027 The first grant after reset release SHALL follow REQ-020 from pointer 0.

Structure
REQ-028 A shared package adder_pkg SHALL hold the default DATA_WIDTH and NUM_REQ constants and the ID_WIDTH function.
REQ-029 The round-robin arbiter SHALL be one sub-module, rr_arbiter (req, pointer, enable -> one-hot grant, granted index).
REQ-030 The existing adder SHALL be instantiated unmodified with DATA_WIDTH_1 = DATA_WIDTH_2 = DATA_WIDTH.

Verification
REQ-031 req_i=0001, op 0x52F2+0x3671, ready high -> gnt_o=0001 cycle N, result_o=0x08963, id 0, valid in cycle N+2 only.
REQ-032 req_i=1111 held, ready high -> grants 0,1,2,3,0 on consecutive cycles, results in same order 2 cycles later.
REQ-033 req 2 with 0xFFFF+0x0001 -> result_o=0x10000, result_id_o=2.
REQ-034 Ready low 3 cycles with both stages full -> result_o held, gnt_o zero, no result lost or repeated after ready rises.
REQ-035 rst pulsed one cycle after grant to requester 1 -> outputs zero at once, no result for it, next grant with req_i=1111 goes to 0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the adder scheduler slice.
package adder_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_NUM_REQ    = 4;

    function automatic int id_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/adder.sv
// Combinational unsigned adder; sum is one bit wider than the widest operand.
module adder #(
    parameter int DATA_WIDTH_1 = 16,
    parameter int DATA_WIDTH_2 = 16,
    parameter int SUM_WIDTH    = ((DATA_WIDTH_1 > DATA_WIDTH_2) ? DATA_WIDTH_1 : DATA_WIDTH_2) + 1
) (
    input  logic [DATA_WIDTH_1-1:0] data1,
    input  logic [DATA_WIDTH_2-1:0] data2,
    output logic [SUM_WIDTH-1:0]    result
);

    assign result = SUM_WIDTH'(data1) + SUM_WIDTH'(data2);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from pointer with wrap, one-hot grant.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] pointer,
    input  logic                enable,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_WIDTH-1:0] gnt_idx
);

    always_comb begin
        int  cand;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(pointer) + i) % NUM_REQ;
            if (enable && !found && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = ID_WIDTH'(cand);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_sched.sv
// Schedules NUM_REQ requesters onto one shared adder: grant, operand stage, result stage.
module adder_sched
    import adder_pkg::*;
#(
    parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int  NUM_REQ    = DEFAULT_NUM_REQ,
    localparam int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data1_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data2_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [DATA_WIDTH:0]           result_o,
    output logic [ID_WIDTH-1:0]           result_id_o,
    output logic                          result_valid_o,
    input  logic                          result_ready_i
);

    logic                  stall;
    logic                  arb_en;
    logic [ID_WIDTH-1:0]   pointer;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic [DATA_WIDTH-1:0] sel_op1;
    logic [DATA_WIDTH-1:0] sel_op2;
    logic [DATA_WIDTH-1:0] s1_op1;
    logic [DATA_WIDTH-1:0] s1_op2;
    logic [ID_WIDTH-1:0]   s1_id;
    logic                  s1_valid;
    logic [DATA_WIDTH:0]   sum;

    assign stall = result_valid_o & ~result_ready_i;
    // An empty stage 1 may still be filled while the result stage is stalled.
    assign arb_en = ~rst & ~(stall & s1_valid);

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req     (req_i),
        .pointer (pointer),
        .enable  (arb_en),
        .gnt     (gnt_o),
        .gnt_idx (gnt_idx)
    );

    assign sel_op1 = data1_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_op2 = data2_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pointer <= '0;
        end else if (|gnt_o) begin
            pointer <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op1   <= '0;
            s1_op2   <= '0;
            s1_id    <= '0;
        end else if (|gnt_o) begin
            s1_valid <= 1'b1;
            s1_op1   <= sel_op1;
            s1_op2   <= sel_op2;
            s1_id    <= gnt_idx;
        end else if (!stall) begin
            s1_valid <= 1'b0;
        end
    end

    adder #(
        .DATA_WIDTH_1 (DATA_WIDTH),
        .DATA_WIDTH_2 (DATA_WIDTH)
    ) u_adder (
        .data1  (s1_op1),
        .data2  (s1_op2),
        .result (sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_valid_o <= 1'b0;
            result_o       <= '0;
            result_id_o    <= '0;
        end else if (!stall) begin
            result_valid_o <= s1_valid;
            if (s1_valid) begin
                result_o    <= sum;
                result_id_o <= s1_id;
            end
        end
    end

endmodule

// File: tb/tb_adder_sched.sv
// Directed bench for adder_sched: table of single transactions plus pipeline/stall/reset sequences.
module tb_adder_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_i;
    logic [63:0] data1_i;
    logic [63:0] data2_i;
    logic [3:0]  gnt_o;
    logic [16:0] result_o;
    logic [1:0]  result_id_o;
    logic        result_valid_o;
    logic        result_ready_i;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [3:0]  req;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [3:0]  gnt;
        logic [16:0] res;
        logic [1:0]  id;
    } vec_t;

    vec_t vecs[7];

    adder_sched #(
        .DATA_WIDTH (16),
        .NUM_REQ    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .data1_i        (data1_i),
        .data2_i        (data2_i),
        .gnt_o          (gnt_o),
        .result_o       (result_o),
        .result_id_o    (result_id_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_i = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Checks a full result beat at the current sample point.
    task automatic check_res(input string name, input logic [16:0] res, input logic [1:0] id);
        check({name, " valid"}, 32'(result_valid_o), 32'd1);
        check({name, " result"}, 32'(result_o), 32'(res));
        check({name, " id"}, 32'(result_id_o), 32'(id));
    endtask

    logic [16:0] seq_sum[4];

    initial begin
        rst = 1'b1;
        req_i = 4'b1111;
        data1_i = '0;
        data2_i = '0;
        result_ready_i = 1'b1;

        vecs[0] = '{4'b0001, 64'h1111_2222_3333_52F2, 64'h4444_5555_6666_3671, 4'b0001, 17'h08963, 2'd0};
        vecs[1] = '{4'b0100, 64'h1000_FFFF_2000_3000, 64'h0100_0001_0200_0300, 4'b0100, 17'h10000, 2'd2};
        vecs[2] = '{4'b1000, 64'h1234_0001_0002_0003, 64'h0FED_0010_0020_0030, 4'b1000, 17'h02221, 2'd3};
        vecs[3] = '{4'b0010, 64'h0005_0006_8000_0007, 64'h0009_000A_8000_000B, 4'b0010, 17'h10000, 2'd1};
        vecs[4] = '{4'b0011, 64'h0000_0000_7777_0101, 64'h0000_0000_1111_0202, 4'b0001, 17'h00303, 2'd0};
        vecs[5] = '{4'b1001, 64'hABCD_0000_0000_5555, 64'h1111_0000_0000_1234, 4'b1000, 17'h0BCDE, 2'd3};
        vecs[6] = '{4'b0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 4'b0000, 17'h00000, 2'd0};

        #1;
        check("reset gnt", 32'(gnt_o), 32'd0);
        check("reset valid", 32'(result_valid_o), 32'd0);
        check("reset result", 32'(result_o), 32'd0);
        check("reset id", 32'(result_id_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_i = '0;

        // Single transactions; pointer carries over between entries.
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            req_i = vecs[v].req;
            data1_i = vecs[v].d1;
            data2_i = vecs[v].d2;
            #1;
            check($sformatf("vec%0d gnt", v), 32'(gnt_o), 32'(vecs[v].gnt));
            @(negedge clk);
            req_i = '0;
            #1;
            check($sformatf("vec%0d valid N+1", v), 32'(result_valid_o), 32'd0);
            @(negedge clk);
            #1;
            if (vecs[v].gnt != 4'b0000)
                check_res($sformatf("vec%0d N+2", v), vecs[v].res, vecs[v].id);
            else
                check($sformatf("vec%0d idle valid", v), 32'(result_valid_o), 32'd0);
            @(negedge clk);
            #1;
            check($sformatf("vec%0d valid N+3", v), 32'(result_valid_o), 32'd0);
        end

        // All requesters held: back-to-back round-robin grants and in-order results.
        do_reset();
        data1_i = 64'h4000_3000_2000_1000;
        data2_i = 64'h0004_0003_0002_0001;
        seq_sum[0] = 17'h01001;
        seq_sum[1] = 17'h02002;
        seq_sum[2] = 17'h03003;
        seq_sum[3] = 17'h04004;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            req_i = (c < 5) ? 4'b1111 : 4'b0000;
            #1;
            check($sformatf("rr c%0d gnt", c), 32'(gnt_o), (c < 5) ? (32'd1 << (c % 4)) : 32'd0);
            if (c >= 2 && c <= 6)
                check_res($sformatf("rr c%0d", c), seq_sum[(c - 2) % 4], 2'((c - 2) % 4));
            else
                check($sformatf("rr c%0d valid", c), 32'(result_valid_o), 32'd0);
        end

        // Back-pressure with both stages full for three cycles.
        do_reset();
        data1_i = 64'h0040_0030_0020_0010;
        data2_i = 64'h0004_0003_0002_0001;
        req_i = 4'b0001;
        #1;
        check("stall c0 gnt", 32'(gnt_o), 32'b0001);
        @(negedge clk);
        req_i = 4'b0010;
        #1;
        check("stall c1 gnt", 32'(gnt_o), 32'b0010);
        check("stall c1 valid", 32'(result_valid_o), 32'd0);
        for (int c = 2; c < 5; c++) begin
            @(negedge clk);
            req_i = 4'b0100;
            result_ready_i = 1'b0;
            #1;
            check($sformatf("stall c%0d gnt", c), 32'(gnt_o), 32'd0);
            check_res($sformatf("stall c%0d", c), 17'h00011, 2'd0);
        end
        @(negedge clk);
        result_ready_i = 1'b1;
        #1;
        check("stall c5 gnt", 32'(gnt_o), 32'b0100);
        check_res("stall c5", 17'h00011, 2'd0);
        @(negedge clk);
        req_i = '0;
        #1;
        check("stall c6 gnt", 32'(gnt_o), 32'd0);
        check_res("stall c6", 17'h00022, 2'd1);
        @(negedge clk);
        #1;
        check_res("stall c7", 17'h00033, 2'd2);
        @(negedge clk);
        #1;
        check("stall c8 valid", 32'(result_valid_o), 32'd0);

        // Stalled result with empty stage 1: one grant still fills stage 1.
        do_reset();
        req_i = 4'b0001;
        @(negedge clk);
        req_i = '0;
        @(negedge clk);
        req_i = 4'b0010;
        result_ready_i = 1'b0;
        #1;
        check("bubble c2 gnt", 32'(gnt_o), 32'b0010);
        check_res("bubble c2", 17'h00011, 2'd0);
        @(negedge clk);
        req_i = '0;
        #1;
        check("bubble c3 gnt", 32'(gnt_o), 32'd0);
        check_res("bubble c3", 17'h00011, 2'd0);
        @(negedge clk);
        result_ready_i = 1'b1;
        #1;
        check_res("bubble c4", 17'h00011, 2'd0);
        @(negedge clk);
        #1;
        check_res("bubble c5", 17'h00022, 2'd1);
        @(negedge clk);
        #1;
        check("bubble c6 valid", 32'(result_valid_o), 32'd0);

        // Reset mid-flight discards work and restarts arbitration at requester 0.
        do_reset();
        req_i = 4'b0001;
        @(negedge clk);
        req_i = 4'b0010;
        #1;
        check("rst c1 gnt", 32'(gnt_o), 32'b0010);
        @(negedge clk);
        req_i = 4'b1111;
        rst = 1'b1;
        #1;
        check("rst c2 gnt", 32'(gnt_o), 32'd0);
        check("rst c2 valid", 32'(result_valid_o), 32'd0);
        check("rst c2 result", 32'(result_o), 32'd0);
        check("rst c2 id", 32'(result_id_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst c3 gnt", 32'(gnt_o), 32'b0001);
        check("rst c3 valid", 32'(result_valid_o), 32'd0);
        @(negedge clk);
        req_i = '0;
        #1;
        check("rst c4 valid", 32'(result_valid_o), 32'd0);
        @(negedge clk);
        #1;
        check_res("rst c5", 17'h00011, 2'd0);
        @(negedge clk);
        #1;
        check("rst c6 valid", 32'(result_valid_o), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
